// File: rtl/uart_rx_if.sv
// Parallel/serial bus of the UART receiver: serial line and frame configuration in,
// received byte and status pulses out.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_IN;
    logic [PRESC_W-1:0]    PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    logic                  RX_BUSY;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversamples the synchronized serial line, majority-votes each bit
// and reports the byte with a one-cycle valid pulse or parity/stop error pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic     CLK,
    input  logic     RST_n,
    uart_rx_if.slave bus
);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic                  rx_meta, rx_s;
    logic [PRESC_W-1:0]    presc_q, edge_cnt;
    logic                  par_en_q, par_typ_q;
    logic [BCW-1:0]        bit_cnt;
    logic [2:0]            smp;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_acc, par_bad, stop_bit;

    logic [PRESC_W-1:0]    half;
    logic                  presc_ok, last_edge, resolve, maj;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        half      = presc_q >> 1;
        presc_ok  = (bus.PRESCALE == PRESC_W'(8))  ||
                    (bus.PRESCALE == PRESC_W'(16)) ||
                    (bus.PRESCALE == PRESC_W'(32));
        last_edge = (edge_cnt == presc_q - PRESC_W'(1));
        resolve   = (edge_cnt == half + PRESC_W'(2));
        maj       = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            state          <= IDLE;
            presc_q        <= PRESC_W'(8);
            edge_cnt       <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            bit_cnt        <= '0;
            smp            <= '0;
            shreg          <= '0;
            par_acc        <= 1'b0;
            par_bad        <= 1'b0;
            stop_bit       <= 1'b1;
            bus.P_DATA     <= '0;
            bus.DATA_VALID <= 1'b0;
            bus.PAR_ERR    <= 1'b0;
            bus.STP_ERR    <= 1'b0;
            bus.RX_BUSY    <= 1'b0;
        end else begin
            rx_meta        <= bus.RX_IN;
            rx_s           <= rx_meta;
            bus.DATA_VALID <= 1'b0;
            bus.PAR_ERR    <= 1'b0;
            bus.STP_ERR    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= last_edge ? '0 : edge_cnt + PRESC_W'(1);
                if (edge_cnt == half - PRESC_W'(1)) smp[0] <= rx_s;
                if (edge_cnt == half)               smp[1] <= rx_s;
                if (edge_cnt == half + PRESC_W'(1)) smp[2] <= rx_s;
            end

            unique case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    // The detection cycle is edge 0 of the start bit.
                    if (!rx_s) begin
                        state       <= START;
                        edge_cnt    <= PRESC_W'(1);
                        presc_q     <= presc_ok ? bus.PRESCALE : PRESC_W'(8);
                        par_en_q    <= bus.PAR_EN;
                        par_typ_q   <= bus.PAR_TYP;
                        par_acc     <= 1'b0;
                        par_bad     <= 1'b0;
                        bus.RX_BUSY <= 1'b1;
                    end
                end
                START: begin
                    if (resolve && maj) begin
                        state       <= IDLE;
                        edge_cnt    <= '0;
                        bus.RX_BUSY <= 1'b0;
                    end else if (last_edge) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (resolve) begin
                        shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                        par_acc <= par_acc ^ maj;
                    end
                    if (last_edge) begin
                        if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                PARITY: begin
                    // Expected bit is data XOR for even parity, inverted for odd.
                    if (resolve)   par_bad <= maj ^ par_acc ^ par_typ_q;
                    if (last_edge) state   <= STOP;
                end
                STOP: begin
                    if (resolve) stop_bit <= maj;
                    if (last_edge) begin
                        state       <= IDLE;
                        bus.RX_BUSY <= 1'b0;
                        bus.STP_ERR <= ~stop_bit;
                        bus.PAR_ERR <= par_bad;
                        if (stop_bit && !par_bad) begin
                            bus.DATA_VALID <= 1'b1;
                            bus.P_DATA     <= shreg;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. It is the downstream stage of the UART transmitter and consumes its serial TX_OUT line. It oversamples the serial line by a runtime prescale, recovers start/data/parity/stop bits by majority vote, and delivers the received byte as a one-cycle valid pulse on a parallel bus with parity and stop error flags. Its frame format and parity convention are identical to the transmitter's, so TX_OUT connects directly to RX_IN in loopback.

Parameters:
DATA_WIDTH, 8, data bits per frame, sent and received LSB first.
PRESC_W, 6, width of the PRESCALE input.

Ports:
CLK  input  1  system clock, rising edge.
RST_n  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high.
PRESCALE  input  PRESC_W  oversampling ratio; legal values are 8, 16 and 32.
PAR_EN  input  1  1 means a parity bit follows the data bits.
PAR_TYP  input  1  1 means odd parity, 0 means even parity (same convention as the transmitter).
P_DATA  output  DATA_WIDTH  last correctly received byte.
DATA_VALID  output  1  one-cycle pulse when a good frame completes.
PAR_ERR  output  1  one-cycle pulse on a parity mismatch.
STP_ERR  output  1  one-cycle pulse when the stop bit is sampled as 0.
RX_BUSY  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, RST_n=0):
  - FSM goes to IDLE; all counters clear.
  - P_DATA=0; DATA_VALID=PAR_ERR=STP_ERR=RX_BUSY=0.
  - Synchronizer flops reset to 1.
  - Reset asserted mid-frame aborts the frame with no output pulse.
- Synchronizer: RX_IN passes through a 2-flop synchronizer. All timing below refers to the synchronized line (rx_s), which lags RX_IN by 2 cycles.
- Configuration latching:
  - PRESCALE, PAR_EN and PAR_TYP are latched on start detection and held constant for the frame.
  - A latched PRESCALE value other than 8, 16 or 32 is treated as 8.
- Counters:
  - edge_cnt runs 0..P-1 within each bit period (P = latched prescale).
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling:
  - rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the three samples, resolved at edge_cnt = P/2+2.
- FSM states and transitions:
  - IDLE: when rx_s=0, go to START with edge_cnt=0. This is the first cycle rx_s is low.
  - START: at majority resolution, if the bit is 1 (glitch), return to IDLE with no pulse. Otherwise, at edge_cnt=P-1, go to DATA.
  - DATA: the majority bit is shifted in LSB first. After bit DATA_WIDTH-1 completes, go to PARITY if PAR_EN=1, else go to STOP.
  - PARITY: the received bit is compared with the computed bit. Computed bit is XOR of the data for even parity, its inverse for odd. At edge_cnt=P-1, go to STOP.
  - STOP: at edge_cnt=P-1, exactly one of the following occurs in the same cycle, then the FSM goes to IDLE:
    - Stop bit 0: STP_ERR pulses.
    - Parity mismatch: PAR_ERR pulses.
    - Both errors: both STP_ERR and PAR_ERR pulse.
    - No error: DATA_VALID pulses and P_DATA updates.
- Error handling: P_DATA is unchanged on any error.
- Back-to-back frames: a new start bit is detected on the first IDLE cycle. No dead cycles are required between frames.
- Frame latency: frame length is (1+DATA_WIDTH+PAR_EN+1)*P cycles. The output pulse occurs on the last cycle of the stop bit period.
- RX_BUSY: rises on the cycle after start detection and falls together with the output pulse.
- Stuck-low line: RX_IN held low forever produces repeated STP_ERR pulses, one per frame length.

Test Plan:
1. PRESCALE=8, PAR_EN=1, PAR_TYP=1, frame for 0xA5 (bits 0,1,0,1,0,0,1,0,1, parity 1, stop 1) -> DATA_VALID pulses once, P_DATA=0xA5, no errors, pulse 88 cycles after rx_s falls.
2. Same frame, PAR_TYP=0, parity bit driven 1 -> PAR_ERR pulse, DATA_VALID=0, P_DATA keeps previous value.
3. PRESCALE=16, PAR_EN=0, 0x3C with stop bit 0 -> STP_ERR pulse at cycle 160, P_DATA unchanged.
4. PRESCALE=32, low glitch of 5 cycles on idle line -> return to IDLE, no pulse of any kind, RX_BUSY high only during START.
5. Loopback with the transmitter at matching bit rate, 0x00, 0xFF, 0x5A back-to-back under odd, even and no parity -> three DATA_VALID pulses per mode with correct bytes, no errors.
6. Assert RST_n=0 in the middle of DATA, then release and send 0x81 -> no pulse for the aborted frame, then P_DATA=0x81 with DATA_VALID.
